// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared types and defaults for the data memory controller slice.
//   state_t                 : controller FSM states (IDLE, BUSY, DONE)
//   DEFAULT_LATENCY         : default access latency in cycles (legal 1..15)
//   DEFAULT_WORD_ADDR_WIDTH : default log2 of the backing array depth in words
//   CNT_WIDTH               : width of the latency counters (holds 0..14)
// -----------------------------------------------------------------------------
package data_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_LATENCY         = 4;
   localparam int DEFAULT_WORD_ADDR_WIDTH = 10;
   localparam int CNT_WIDTH               = 4;

endpackage : data_mem_pkg

// File: rtl/data_mem_array.sv
// -----------------------------------------------------------------------------
// data_mem_array
// Word-addressed backing store: one write port, one synchronous read port.
// The storage itself is never reset; only the read-data register is.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (read-data register only)
//   we     in   write enable
//   waddr  in   write word index
//   wdata  in   write data
//   re     in   read enable; rdata loads on the same edge
//   raddr  in   read word index
//   rdata  out  registered read data, holds until the next enabled read
// -----------------------------------------------------------------------------
module data_mem_array
   import data_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = DEFAULT_WORD_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // NOTE: the storage array has no reset so it maps onto RAM macros;
   // contents survive rst_n and start undefined after power-up.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // NOTE: sequential state is assigned with non-blocking <= so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule : data_mem_array

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Fixed-latency request/ready controller in front of data_mem_array.
// A request is accepted in IDLE, counted down in BUSY for LATENCY cycles and
// acknowledged with a one-cycle mem_ready pulse in DONE.
//
// Optional feature macro: MEM_POST_WRITE_EN
//   Adds a one-entry posted-write buffer. Writes are acknowledged one cycle
//   after acceptance and drain into the array LATENCY cycles later, while
//   reads keep running. Undefined (default): writes use the normal path and
//   wb_full is tied low.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   mem_read   in   read request (level, held until mem_ready)
//   mem_write  in   write request (level, held until mem_ready); wins over read
//   mem_addr   in   byte address; word index = [WORD_ADDR_WIDTH+1:2], rest ignored
//   mem_wdata  in   write data, captured at acceptance
//   mem_ready  out  one-cycle completion pulse
//   mem_rdata  out  registered read data, changes only when a read completes
//   wb_full    out  posted-write buffer occupied
// -----------------------------------------------------------------------------
module data_mem_ctrl
   import data_mem_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int WORD_ADDR_WIDTH = DEFAULT_WORD_ADDR_WIDTH,
   parameter int LATENCY         = DEFAULT_LATENCY
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [DATA_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_ready,
   output logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  wb_full
);

   localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);

   state_t                     state, state_next;
   logic [CNT_WIDTH-1:0]       cnt;
   logic                       lat_wr;
   logic [WORD_ADDR_WIDTH-1:0] lat_idx;
   logic [WORD_ADDR_WIDTH-1:0] req_idx;
   logic                       accept, acc_wr, access_done;
   logic                       arr_we, arr_re;
   logic [WORD_ADDR_WIDTH-1:0] arr_waddr;
   logic [DATA_WIDTH-1:0]      arr_wdata, arr_rdata;
   logic                       unused_addr;

`ifdef MEM_POST_WRITE_EN
   logic                       wb_valid;
   logic [CNT_WIDTH-1:0]       wb_cnt;
   logic [WORD_ADDR_WIDTH-1:0] wb_idx;
   logic [DATA_WIDTH-1:0]      wb_data;
   logic                       fwd_sel;
   logic [DATA_WIDTH-1:0]      fwd_data;
`else
   logic [DATA_WIDTH-1:0]      lat_wdata;
`endif

   // Byte offset and bits above the array depth are dropped, so addresses wrap.
   assign req_idx     = mem_addr[WORD_ADDR_WIDTH+1:2];
   assign unused_addr = ^{mem_addr[DATA_WIDTH-1:WORD_ADDR_WIDTH+2], mem_addr[1:0]};

   // Request decode: a write takes priority when both requests are high.
   always_comb begin
      acc_wr = mem_write;
`ifdef MEM_POST_WRITE_EN
      // A write must wait in IDLE while the buffer still holds a prior write.
      accept = (state == IDLE) && (mem_write ? !wb_valid : mem_read);
`else
      accept = (state == IDLE) && (mem_read || mem_write);
`endif
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
`ifdef MEM_POST_WRITE_EN
               state_next = acc_wr ? DONE : BUSY;
`else
               state_next = BUSY;
`endif
            end
         end
         BUSY:    if (cnt == '0) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs and array port steering
   always_comb begin
      mem_ready   = (state == DONE);
      access_done = (state == BUSY) && (cnt == '0);
      arr_re      = access_done && !lat_wr;
`ifdef MEM_POST_WRITE_EN
      arr_we      = wb_valid && (wb_cnt == '0);
      arr_waddr   = wb_idx;
      arr_wdata   = wb_data;
`else
      arr_we      = access_done && lat_wr;
      arr_waddr   = lat_idx;
      arr_wdata   = lat_wdata;
`endif
   end

   // Request latch and latency counter. The counter parks at zero after the
   // completing edge and is reloaded by the next acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         lat_wr    <= 1'b0;
         lat_idx   <= '0;
`ifndef MEM_POST_WRITE_EN
         lat_wdata <= '0;
`endif
      end else if (accept) begin
         cnt       <= CNT_LOAD;
         lat_wr    <= acc_wr;
         lat_idx   <= req_idx;
`ifndef MEM_POST_WRITE_EN
         lat_wdata <= mem_wdata;
`endif
      end else if ((state == BUSY) && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

`ifdef MEM_POST_WRITE_EN
   // Posted-write buffer: filled at write acceptance, drained LATENCY edges later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid <= 1'b0;
         wb_cnt   <= '0;
         wb_idx   <= '0;
         wb_data  <= '0;
      end else if (accept && acc_wr) begin
         wb_valid <= 1'b1;
         wb_cnt   <= CNT_LOAD;
         wb_idx   <= req_idx;
         wb_data  <= mem_wdata;
      end else if (wb_valid) begin
         if (wb_cnt == '0) begin
            wb_valid <= 1'b0;
         end else begin
            wb_cnt <= wb_cnt - 1'b1;
         end
      end
   end

   // A read hitting the pending entry returns the buffered data; the hit is
   // judged on pre-edge state, so a drain on the same edge still forwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_sel  <= 1'b0;
         fwd_data <= '0;
      end else if (arr_re) begin
         fwd_sel  <= wb_valid && (wb_idx == lat_idx);
         fwd_data <= wb_data;
      end
   end

   assign wb_full   = wb_valid;
   assign mem_rdata = fwd_sel ? fwd_data : arr_rdata;
`else
   assign wb_full   = 1'b0;
   assign mem_rdata = arr_rdata;
`endif

   data_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (WORD_ADDR_WIDTH)
   ) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (arr_we),
      .waddr (arr_waddr),
      .wdata (arr_wdata),
      .re    (arr_re),
      .raddr (lat_idx),
      .rdata (arr_rdata)
   );

endmodule : data_mem_ctrl

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Directed testbench for data_mem_ctrl (LATENCY=4, WORD_ADDR_WIDTH=10).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// "edges" below counts rising edges from raising a request until mem_ready is
// seen: an access raised in IDLE is accepted on edge 1 and, with latency L,
// completes on edge 1+L. Raised during DONE, it costs one extra edge.
// Honors MEM_POST_WRITE_EN for the posted-write expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_mem_ctrl;

   localparam int DW  = 32;
   localparam int AW  = 10;
   localparam int LAT = 4;
`ifdef MEM_POST_WRITE_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif
   localparam int RD_EDGES = LAT + 1;
   localparam int WR_EDGES = POSTED ? 1 : LAT + 1;

   logic          clk;
   logic          rst_n;
   logic          mem_read;
   logic          mem_write;
   logic [DW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ready;
   logic [DW-1:0] mem_rdata;
   logic          wb_full;

   int checks   = 0;
   int failures = 0;

   data_mem_ctrl #(
      .DATA_WIDTH      (DW),
      .WORD_ADDR_WIDTH (AW),
      .LATENCY         (LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .wb_full   (wb_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Raise a request and wait (bounded) for mem_ready; edges = -1 on timeout.
   // With hold set, the request stays asserted through the DONE cycle.
   task automatic do_access(input logic wr, input logic rd, input logic [DW-1:0] addr,
                            input logic [DW-1:0] wdata, input bit hold, output int edges);
      mem_write = wr;
      mem_read  = rd;
      mem_addr  = addr;
      mem_wdata = wdata;
      edges     = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (mem_ready === 1'b1) begin
            edges = i;
            break;
         end
      end
      if (!hold) begin
         mem_write = 1'b0;
         mem_read  = 1'b0;
      end
   endtask

   task automatic idle_edges(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_edges(3);
      checks++;
      if (mem_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready: got %b expected 0", mem_ready);
      end
      checks++;
      if (mem_rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_rdata: got %h expected 00000000", mem_rdata);
      end
      checks++;
      if (wb_full !== 1'b0) begin
         failures++;
         $display("FAIL reset_wb_full: got %b expected 0", wb_full);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_write_read();
      int e;
      do_access(1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 1'b0, e);
      checks++;
      if (e !== WR_EDGES) begin
         failures++;
         $display("FAIL wr40_edges: got %0d expected %0d", e, WR_EDGES);
      end
      idle_edges(1);
      checks++;
      if (mem_ready !== 1'b0) begin
         failures++;
         $display("FAIL ready_pulse_width: got %b expected 0", mem_ready);
      end
      do_access(1'b0, 1'b1, 32'h40, 32'h0, 1'b0, e);
      checks++;
      if (e !== RD_EDGES) begin
         failures++;
         $display("FAIL rd40_edges: got %0d expected %0d", e, RD_EDGES);
      end
      checks++;
      if (mem_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL rd40_data: got %h expected deadbeef", mem_rdata);
      end
      idle_edges(1);
      checks++;
      if (mem_ready !== 1'b0) begin
         failures++;
         $display("FAIL rd_pulse_width: got %b expected 0", mem_ready);
      end
   endtask

   task automatic test_back_to_back();
      int e;
      // Write held through DONE, dropped and replaced by a read one cycle later.
      do_access(1'b1, 1'b0, 32'h80, 32'h11112222, 1'b1, e);
      checks++;
      if (e !== WR_EDGES) begin
         failures++;
         $display("FAIL b2b_wr_edges: got %0d expected %0d", e, WR_EDGES);
      end
      idle_edges(1);
      checks++;
      if (mem_ready !== 1'b0) begin
         failures++;
         $display("FAIL b2b_no_dup_ready: got %b expected 0", mem_ready);
      end
      do_access(1'b0, 1'b1, 32'h80, 32'h0, 1'b0, e);
      checks++;
      if (e !== RD_EDGES) begin
         failures++;
         $display("FAIL b2b_rd_edges: got %0d expected %0d", e, RD_EDGES);
      end
      checks++;
      if (mem_rdata !== 32'h11112222) begin
         failures++;
         $display("FAIL b2b_rd_data: got %h expected 11112222", mem_rdata);
      end
      // Raised during DONE: ignored there, accepted on the following edge.
      do_access(1'b0, 1'b1, 32'h40, 32'h0, 1'b0, e);
      checks++;
      if (e !== RD_EDGES + 1) begin
         failures++;
         $display("FAIL b2b_rd2_edges: got %0d expected %0d", e, RD_EDGES + 1);
      end
      checks++;
      if (mem_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL b2b_rd2_data: got %h expected deadbeef", mem_rdata);
      end
      idle_edges(1);
   endtask

   task automatic test_both_high();
      int e;
      do_access(1'b1, 1'b1, 32'h8, 32'h5, 1'b0, e);
      checks++;
      if (e !== WR_EDGES) begin
         failures++;
         $display("FAIL both_edges: got %0d expected %0d", e, WR_EDGES);
      end
      idle_edges(1);
      checks++;
      if (mem_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL both_rdata_held: got %h expected deadbeef", mem_rdata);
      end
      do_access(1'b0, 1'b1, 32'h8, 32'h0, 1'b0, e);
      checks++;
      if (e !== RD_EDGES) begin
         failures++;
         $display("FAIL both_rd_edges: got %0d expected %0d", e, RD_EDGES);
      end
      checks++;
      if (mem_rdata !== 32'h5) begin
         failures++;
         $display("FAIL both_rd_data: got %h expected 00000005", mem_rdata);
      end
      idle_edges(1);
   endtask

   task automatic test_alias();
      int e;
      // 0x1000_0040 and 0x43 both map to word 16, same as 0x40.
      do_access(1'b1, 1'b0, 32'h1000_0040, 32'h77, 1'b0, e);
      idle_edges(1);
      do_access(1'b0, 1'b1, 32'h40, 32'h0, 1'b0, e);
      checks++;
      if (mem_rdata !== 32'h77) begin
         failures++;
         $display("FAIL alias_hi_bits: got %h expected 00000077", mem_rdata);
      end
      idle_edges(1);
      do_access(1'b1, 1'b0, 32'h43, 32'h88, 1'b0, e);
      idle_edges(1);
      do_access(1'b0, 1'b1, 32'h1000_0040, 32'h0, 1'b0, e);
      checks++;
      if (mem_rdata !== 32'h88) begin
         failures++;
         $display("FAIL alias_byte_bits: got %h expected 00000088", mem_rdata);
      end
      idle_edges(1);
   endtask

   task automatic test_reset_mid_access();
      int e;
      int ready_cnt;
      do_access(1'b1, 1'b0, 32'h10, 32'hCAFE, 1'b0, e);
      idle_edges(LAT + 1);
      // Accept on edge 1, then reset during the second BUSY cycle.
      mem_write = 1'b1;
      mem_addr  = 32'h10;
      mem_wdata = 32'h1234;
      ready_cnt = 0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         if (mem_ready === 1'b1) ready_cnt++;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (ready_cnt !== (POSTED ? 1 : 0)) begin
         failures++;
         $display("FAIL rstmid_early_ready: got %0d expected %0d", ready_cnt, POSTED ? 1 : 0);
      end
      checks++;
      if (mem_ready !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_ready: got %b expected 0", mem_ready);
      end
      checks++;
      if (mem_rdata !== 32'h0) begin
         failures++;
         $display("FAIL rstmid_rdata: got %h expected 00000000", mem_rdata);
      end
      checks++;
      if (wb_full !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_wb_full: got %b expected 0", wb_full);
      end
      mem_write = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ready_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (mem_ready === 1'b1) ready_cnt++;
      end
      checks++;
      if (ready_cnt !== 0) begin
         failures++;
         $display("FAIL rstmid_late_ready: got %0d expected 0", ready_cnt);
      end
      do_access(1'b0, 1'b1, 32'h10, 32'h0, 1'b0, e);
      checks++;
      if (e !== RD_EDGES) begin
         failures++;
         $display("FAIL rstmid_rd_edges: got %0d expected %0d", e, RD_EDGES);
      end
      checks++;
      if (mem_rdata !== 32'hCAFE) begin
         failures++;
         $display("FAIL rstmid_array_kept: got %h expected 0000cafe", mem_rdata);
      end
      idle_edges(1);
   endtask

`ifdef MEM_POST_WRITE_EN
   task automatic test_posted_write();
      int e;
      do_access(1'b1, 1'b0, 32'h20, 32'hA5, 1'b0, e);
      checks++;
      if (e !== 1) begin
         failures++;
         $display("FAIL pw_wr_edges: got %0d expected 1", e);
      end
      checks++;
      if (wb_full !== 1'b1) begin
         failures++;
         $display("FAIL pw_wb_full: got %b expected 1", wb_full);
      end
      do_access(1'b0, 1'b1, 32'h20, 32'h0, 1'b0, e);
      checks++;
      if (e !== RD_EDGES + 1) begin
         failures++;
         $display("FAIL pw_rd_edges: got %0d expected %0d", e, RD_EDGES + 1);
      end
      checks++;
      if (mem_rdata !== 32'hA5) begin
         failures++;
         $display("FAIL pw_rd_data: got %h expected 000000a5", mem_rdata);
      end
      idle_edges(LAT + 1);
      // Fill on edge F; second write raised at F: stalls until drain at F+4,
      // accepted at F+5.
      do_access(1'b1, 1'b0, 32'h30, 32'h1, 1'b0, e);
      do_access(1'b1, 1'b0, 32'h24, 32'h5A, 1'b0, e);
      checks++;
      if (e !== LAT + 1) begin
         failures++;
         $display("FAIL pw_stall_edges: got %0d expected %0d", e, LAT + 1);
      end
      checks++;
      if (wb_full !== 1'b1) begin
         failures++;
         $display("FAIL pw_stall_wb_full: got %b expected 1", wb_full);
      end
      idle_edges(1);
      do_access(1'b0, 1'b1, 32'h30, 32'h0, 1'b0, e);
      checks++;
      if (mem_rdata !== 32'h1) begin
         failures++;
         $display("FAIL pw_rd30_data: got %h expected 00000001", mem_rdata);
      end
      idle_edges(1);
      do_access(1'b0, 1'b1, 32'h24, 32'h0, 1'b0, e);
      checks++;
      if (mem_rdata !== 32'h5A) begin
         failures++;
         $display("FAIL pw_rd24_data: got %h expected 0000005a", mem_rdata);
      end
      idle_edges(1);
   endtask
`endif

   initial begin
      rst_n     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_both_high();
      test_alias();
      test_reset_mid_access();
`ifdef MEM_POST_WRITE_EN
      test_posted_write();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_data_mem_ctrl

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, word width; WORD_ADDR_WIDTH, 10, backing array holds 2**WORD_ADDR_WIDTH words; LATENCY, 4, access latency in cycles (legal range 1..15).
REQ-002 Ports SHALL be: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 mem_read  in  1  read request, level, held by requester until mem_ready.
REQ-004 mem_write  in  1  write request, level, held by requester until mem_ready.
REQ-005 mem_addr  in  DATA_WIDTH  byte address; bits [1:0] ignored; word index = bits [WORD_ADDR_WIDTH+1:2]; upper bits ignored (wrap).
REQ-006 mem_wdata  in  DATA_WIDTH  write data, sampled when request accepted.
REQ-007 mem_ready  out  1  single-cycle completion pulse.
REQ-008 mem_rdata  out  DATA_WIDTH  read data, registered.
REQ-009 wb_full  out  1  posted-write buffer occupied (constant 0 when feature compiled out).

Function
REQ-010 FSM SHALL have states IDLE, BUSY, DONE.
REQ-011 In IDLE, a rising edge with mem_read or mem_write high SHALL latch addr, wdata and op, load counter with LATENCY-1, and enter BUSY.
REQ-012 If mem_read and mem_write are both high at acceptance, SHALL treat as write.
REQ-013 In BUSY, counter SHALL decrement each edge; the edge at which counter==0 SHALL perform the access, set mem_ready=1, enter DONE.
REQ-014 mem_ready SHALL be high LATENCY cycles after the accepting edge and for exactly one cycle (state DONE).
REQ-015 In DONE, requests SHALL be ignored; next edge returns to IDLE, so a new request presented the cycle after mem_ready is accepted with no bubble beyond DONE.
REQ-016 Read SHALL load mem_rdata from array[latched index] at the completing edge; mem_rdata SHALL hold until the next read completes (writes never alter it).
REQ-017 Write SHALL update array[latched index] with latched wdata at the completing edge.
REQ-018 Requests deasserted while BUSY SHALL NOT abort the access.

Reset
REQ-019 On rst_n low: state=IDLE, counter=0, mem_ready=0, mem_rdata=0, wb_full=0, buffer invalid; array contents SHALL NOT be reset.
REQ-020 Reset mid-access SHALL discard the access; an uncommitted write (including buffered) SHALL be lost.

Configuration
REQ-021 Macro MEM_POST_WRITE_EN SHALL enable a one-entry posted-write buffer; without it writes follow REQ-011..017 and wb_full=0.
REQ-022 With it: write accepted in IDLE with buffer empty SHALL go straight to DONE (mem_ready one cycle after acceptance), fill buffer, set wb_full.
REQ-023 Buffer SHALL drain into the array LATENCY cycles after fill, then clear wb_full; drain runs concurrently with reads.
REQ-024 Write arriving while wb_full SHALL wait in IDLE (not accepted) until drain completes.
REQ-025 Read whose index matches the valid buffer entry SHALL return buffer data at normal latency; drain and read completing same edge SHALL return the new data.

Structure
REQ-026 Package data_mem_pkg SHALL hold the state enum, DEFAULT_LATENCY and DEFAULT_WORD_ADDR_WIDTH.
REQ-027 Storage SHALL be a sub-module data_mem_array (single write port, synchronous read, no reset).

Verification
REQ-028 LATENCY=4, write 0xDEADBEEF to 0x40, then read 0x40 -> ready exactly 4 cycles after each accept, rdata=0xDEADBEEF.
REQ-029 Write-back then read back-to-back: mem_write dropped and mem_read raised cycle after ready -> second access accepted at DONE->IDLE edge, no duplicate write.
REQ-030 Both read and write high, addr 0x8 data 0x5 -> write performed, rdata unchanged.
REQ-031 rst_n low at BUSY cycle 2 of write 0x1234 to 0x10 -> no ready, array[4] unchanged, outputs zero.
REQ-032 MEM_POST_WRITE_EN: write 0xA5 to 0x20, read 0x20 immediately -> write ready after 1 cycle, read returns 0xA5; second write during wb_full stalls until drain.
REQ-033 Address 0x1000_0040 with WORD_ADDR_WIDTH=10 -> aliases word 16.
